// File: rtl/ir_encoder.sv
// ir_encoder: pulse-distance IR frame transmitter (sync burst/silence, 32 bits MSB first, stop dip, gap).
// Optional IR_CARRIER_EN: bursts are modulated by a square carrier for driving an IR LED directly.
module ir_encoder #(
  parameter int SBD          = 900,
  parameter int SSD          = 450,
  parameter int BBD          = 60,
  parameter int BSD0         = 60,
  parameter int BSD1         = 160,
  parameter int GAP          = 50,
  parameter int CARRIER_HALF = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] code_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        signal_out,
  output logic        busy_out,
  output logic        done_out,
  output logic [2:0]  state_out
);

  localparam int MAX_A  = (SBD > SSD) ? SBD : SSD;
  localparam int MAX_B  = (BBD > BSD0) ? BBD : BSD0;
  localparam int MAX_C  = (BSD1 > GAP) ? BSD1 : GAP;
  localparam int MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_D  = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int CW     = $clog2(MAX_D) + 1;

  localparam logic [CW-1:0] D_SBD  = CW'(SBD);
  localparam logic [CW-1:0] D_SSD  = CW'(SSD);
  localparam logic [CW-1:0] D_BBD  = CW'(BBD);
  localparam logic [CW-1:0] D_BSD0 = CW'(BSD0);
  localparam logic [CW-1:0] D_BSD1 = CW'(BSD1);
  localparam logic [CW-1:0] D_GAP  = CW'(GAP);

  if (SBD < 1 || SSD < 1 || BBD < 1 || BSD0 < 1 || BSD1 < 1 || GAP < 1 || CARRIER_HALF < 1) begin : g_bad_params
    $error("ir_encoder: all timing parameters must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SYNC_BURST = 3'd1,
    S_SYNC_SIL   = 3'd2,
    S_BIT_BURST  = 3'd3,
    S_BIT_SIL    = 3'd4,
    S_STOP_BURST = 3'd5,
    S_GAP        = 3'd6
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next, w_dur;
  logic [31:0]   r_shift, w_shift_next;
  logic [5:0]    r_bits, w_bits_next;
  logic          r_signal, w_signal_next;
  logic          r_done, w_done_next;
  logic          w_last, w_burst_next;

  always_comb begin
    w_dur = '0;
    case (r_state)
      S_SYNC_BURST: w_dur = D_SBD;
      S_SYNC_SIL:   w_dur = D_SSD;
      S_BIT_BURST:  w_dur = D_BBD;
      S_BIT_SIL:    w_dur = r_shift[31] ? D_BSD1 : D_BSD0;
      S_STOP_BURST: w_dur = D_BBD;
      S_GAP:        w_dur = D_GAP;
      default:      w_dur = '0;
    endcase
    w_last = (r_cnt == w_dur - CW'(1));
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_bits_next  = r_bits;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid_in) begin
          w_shift_next = code_in;
          w_bits_next  = '0;
          w_state_next = S_SYNC_BURST;
        end
      end
      S_SYNC_BURST: if (w_last) w_state_next = S_SYNC_SIL;
      S_SYNC_SIL:   if (w_last) w_state_next = S_BIT_BURST;
      S_BIT_BURST:  if (w_last) w_state_next = S_BIT_SIL;
      S_BIT_SIL: begin
        if (w_last) begin
          w_shift_next = {r_shift[30:0], 1'b0};
          w_bits_next  = r_bits + 6'd1;
          w_state_next = (r_bits == 6'd31) ? S_STOP_BURST : S_BIT_BURST;
        end
      end
      S_STOP_BURST: begin
        if (w_last) begin
          w_state_next = S_GAP;
          w_done_next  = 1'b1;
        end
      end
      S_GAP:   if (w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    // Every state change restarts the duration count; IDLE keeps it parked at zero.
    w_cnt_next   = (w_state_next != r_state || r_state == S_IDLE) ? '0 : r_cnt + CW'(1);
    w_burst_next = (w_state_next == S_SYNC_BURST) || (w_state_next == S_BIT_BURST) ||
                   (w_state_next == S_STOP_BURST);
  end

`ifdef IR_CARRIER_EN
  localparam int PW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(CARRIER_HALF - 1);

  logic [PW-1:0] r_ph, w_ph_next;
  logic          r_car, w_car_next;

  // Carrier phase restarts low on every burst entry so each burst has the same shape.
  always_comb begin
    w_ph_next  = r_ph + PW'(1);
    w_car_next = r_car;
    if (!w_burst_next || w_state_next != r_state) begin
      w_ph_next  = '0;
      w_car_next = 1'b0;
    end else if (r_ph == PH_LAST) begin
      w_ph_next  = '0;
      w_car_next = ~r_car;
    end
    w_signal_next = w_burst_next ? w_car_next : 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ph  <= '0;
      r_car <= 1'b0;
    end else begin
      r_ph  <= w_ph_next;
      r_car <= w_car_next;
    end
  end
`else
  always_comb w_signal_next = ~w_burst_next;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_bits   <= '0;
      r_signal <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_shift  <= w_shift_next;
      r_bits   <= w_bits_next;
      r_signal <= w_signal_next;
      r_done   <= w_done_next;
    end
  end

  assign ready_out  = (r_state == S_IDLE);
  assign busy_out   = (r_state != S_IDLE);
  assign signal_out = r_signal;
  assign done_out   = r_done;
  assign state_out  = r_state;

endmodule

// File: tb/tb_ir_encoder.sv
// tb_ir_encoder: scoreboard bench; stimulus pushes expected line runs and done/ready cycles,
// a negedge monitor measures signal_out run lengths and pops/compares them.
module tb_ir_encoder;

  localparam int SBD = 900, SSD = 450, BBD = 60, BSD0 = 60, BSD1 = 160, GAP = 50, CH = 2;
`ifdef IR_CARRIER_EN
  localparam int EXP_LEFT = 1;
`else
  localparam int EXP_LEFT = 0;
`endif

  typedef struct {
    bit level;
    int len;
  } run_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] code_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_out, signal_out, busy_out, done_out;
  logic [2:0]  state_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_k = 0;
  bit pending = 1'b0;
  run_t run_q[$];
  int done_q[$];
  int ready_q[$];

  ir_encoder #(
    .SBD(SBD), .SSD(SSD), .BBD(BBD), .BSD0(BSD0), .BSD1(BSD1), .GAP(GAP), .CARRIER_HALF(CH)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .code_in(code_in),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .signal_out(signal_out),
    .busy_out(busy_out),
    .done_out(done_out),
    .state_out(state_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic push_run(input bit level, input int len);
    run_t r;
    if (run_q.size() > 0 && run_q[$].level == level) begin
      r = run_q.pop_back();
      r.len = (r.len == 0 || len == 0) ? 0 : r.len + len;
      run_q.push_back(r);
    end else begin
      r.level = level;
      r.len   = len;
      run_q.push_back(r);
    end
  endtask

  task automatic push_burst(input int len);
`ifdef IR_CARRIER_EN
    for (int i = 0; i < len; i += CH)
      push_run(((i / CH) % 2) == 1, (len - i < CH) ? len - i : CH);
`else
    push_run(1'b0, len);
`endif
  endtask

  task automatic push_frame(input logic [31:0] code, input int gap_exp);
    int k;
    int len;
    k = cyc + 1;
    if (pending) push_run(1'b1, gap_exp);
    push_burst(SBD);
    push_run(1'b1, SSD);
    len = SBD + SSD;
    for (int i = 31; i >= 0; i--) begin
      push_burst(BBD);
      push_run(1'b1, code[i] ? BSD1 : BSD0);
      len += BBD + (code[i] ? BSD1 : BSD0);
    end
    push_burst(BBD);
    len += BBD;
    done_q.push_back(k + len);
    ready_q.push_back(k + len + GAP);
    pending = 1'b1;
    $display("accept code=%08h at cycle %0d, expected frame length %0d", code, k, len);
  endtask

  task automatic send(input logic [31:0] code, input int gap_exp, input bit hold);
    int n;
    code_in  = code;
    valid_in = 1'b1;
    n = 0;
    while (!ready_out && n < 20000) begin
      tick();
      n++;
    end
    if (!ready_out) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready_out stayed 0 for %0d cycles", n);
    end else begin
      push_frame(code, gap_exp);
    end
    tick();
    last_k = cyc;
    if (!hold) valid_in = 1'b0;
  endtask

  task automatic wait_done(output int at);
    int n;
    n = 0;
    while (!done_out && n < 20000) begin
      tick();
      n++;
    end
    if (!done_out) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done_out within %0d cycles", n);
    end
    at = cyc;
  endtask

  task automatic wait_ready(output int at);
    int n;
    n = 0;
    while (!ready_out && n < 20000) begin
      tick();
      n++;
    end
    if (!ready_out) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: ready_out stayed 0 for %0d cycles", n);
    end
    at = cyc;
  endtask

  // Monitor: run lengths of signal_out, done pulses and ready rises against the scoreboard.
  bit   mon_discard = 1'b1;
  bit   mon_level = 1'b1;
  int   mon_len = 0;
  logic mon_prev_ready = 1'b1;

  always @(negedge clk_in) begin
    run_t e;
    if (rst_in) begin
      mon_discard    = 1'b1;
      mon_level      = signal_out;
      mon_len        = 1;
      mon_prev_ready = ready_out;
    end else begin
      if (signal_out == mon_level) begin
        mon_len++;
      end else begin
        if (!mon_discard) begin
          if (run_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL run_unexpected: level %0d run of %0d with empty scoreboard", mon_level, mon_len);
          end else begin
            e = run_q.pop_front();
            check("run_level", int'(mon_level), int'(e.level));
            if (e.len != 0) check("run_len", mon_len, e.len);
          end
        end
        mon_discard = 1'b0;
        mon_level   = signal_out;
        mon_len     = 1;
      end
      if (done_out) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: done_out pulse at cycle %0d", cyc);
        end else begin
          check("done_cycle", cyc, done_q.pop_front());
          $display("done pulse at cycle %0d", cyc);
        end
      end
      if (ready_out && !mon_prev_ready) begin
        if (ready_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ready_unexpected: ready_out rose at cycle %0d", cyc);
        end else begin
          check("ready_cycle", cyc, ready_q.pop_front());
        end
      end
      mon_prev_ready = ready_out;
    end
  end

  initial begin
    int t_done;
    int t_ready;
    int k;

    repeat (3) tick();
    check("rst_signal", int'(signal_out), 1);
    check("rst_ready", int'(ready_out), 1);
    check("rst_busy", int'(busy_out), 0);
    check("rst_done", int'(done_out), 0);
    check("rst_state", int'(state_out), 0);
    rst_in = 1'b0;
    repeat (5) tick();

    // Single DEADBEEF frame: 7650 cycles to stop-dip end, ready 50 later.
    send(32'hDEADBEEF, 0, 1'b0);
    k = last_k;
    check("state_sync_burst", int'(state_out), 1);
    check("busy_in_frame", int'(busy_out), 1);
    wait_done(t_done);
    check("deadbeef_len", t_done - k, 7650);
    wait_ready(t_ready);
    check("deadbeef_ready_gap", t_ready - t_done, 50);
    repeat (20) tick();

    // valid_in pulse while busy must be ignored.
    send(32'hDEADBEEF, 0, 1'b0);
    k = last_k;
    while (cyc < k + 1999) tick();
    check("ignore_ready_low", int'(ready_out), 0);
    code_in  = 32'hFFFFFFFF;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    wait_done(t_done);
    check("ignore_len", t_done - k, 7650);
    wait_ready(t_ready);
    repeat (10) tick();

    // A5A55A5A: 6850-cycle frame.
    send(32'hA5A55A5A, 0, 1'b0);
    k = last_k;
    wait_done(t_done);
    check("a5_len", t_done - k, 6850);
    wait_ready(t_ready);
    repeat (10) tick();

    // Back-to-back with valid held: 51 high cycles between frames.
    send(32'h12345678, 0, 1'b1);
    send(32'h9ABCDEF0, GAP + 1, 1'b0);
    k = last_k;
    wait_done(t_done);
    check("b2b_second_len", t_done - k, 7150);
    wait_ready(t_ready);
    repeat (10) tick();

    // One-cycle reset at cycle 1200 of a frame.
    send(32'hDEADBEEF, 0, 1'b0);
    k = last_k;
    while (cyc < k + 1199) tick();
    rst_in = 1'b1;
    run_q.delete();
    done_q.delete();
    ready_q.delete();
    pending = 1'b0;
    tick();
    check("midrst_signal", int'(signal_out), 1);
    check("midrst_ready", int'(ready_out), 1);
    check("midrst_state", int'(state_out), 0);
    check("midrst_done", int'(done_out), 0);
    rst_in = 1'b0;
    repeat (100) tick();
    send(32'h0000FFFF, 0, 1'b0);
    k = last_k;
    wait_done(t_done);
    check("after_rst_len", t_done - k, 6850);
    wait_ready(t_ready);
    repeat (10) tick();

    check("runs_left", run_q.size(), EXP_LEFT);
    check("done_left", done_q.size(), 0);
    check("ready_left", ready_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
